// File: rtl/sipo_rv_if.sv
// Handshake and data bundle for sipo_rv.
// slave: the buffer's view. master: the driving/observing side's view.
interface sipo_rv_if #(
   parameter int unsigned width_p = 8,
   parameter int unsigned depth_p = 128,
   parameter int unsigned lanes_p = 1
);
   localparam int unsigned beats_lp = depth_p / lanes_p;
   localparam int unsigned cnt_w_lp = $clog2(beats_lp + 1);

   logic                         valid_i;
   logic                         ready_o;
   logic [width_p*lanes_p-1:0]   data_i;
   logic                         valid_o;
   logic                         ready_i;
   logic [width_p*depth_p-1:0]   data_o;
   logic [cnt_w_lp-1:0]          count_o;

   modport slave (
      input  valid_i, data_i, ready_i,
      output ready_o, valid_o, data_o, count_o
   );

   modport master (
      output valid_i, data_i, ready_i,
      input  ready_o, valid_o, data_o, count_o
   );
endinterface

// File: rtl/sipo_rv.sv
// Multi-lane serial-in/parallel-out frame buffer with valid/ready on both sides.
// Collects depth_p elements, lanes_p per beat, and presents them as one wide word
// until the consumer accepts it. A beat offered in the same cycle the frame is taken
// becomes beat 0 of the next frame.
// Optional build macro SIPO_RV_CLEAR_ON_RESET_EN: reset also zeroes the storage.
module sipo_rv #(
   parameter int unsigned width_p = 8,
   parameter int unsigned depth_p = 128,
   parameter int unsigned lanes_p = 1
) (
   input logic      clk_i,
   input logic      reset_i,
   sipo_rv_if.slave bus
);
   localparam int unsigned beats_lp = depth_p / lanes_p;
   localparam int unsigned cnt_w_lp = $clog2(beats_lp + 1);

   typedef enum logic [0:0] {StFill, StFull} state_e;

   state_e                            state_q, state_d;
   logic [cnt_w_lp-1:0]               cnt_q, cnt_d;
   logic [depth_p-1:0][width_p-1:0]   mem_q, mem_d;

   logic                              ready;
   logic                              accept;
   logic [cnt_w_lp-1:0]               wr_beat;

   // Handshake decode; reset suppresses the write so storage is untouched by it.
   always_comb begin
      ready   = (state_q == StFill) ? 1'b1 : bus.ready_i;
      accept  = bus.valid_i && ready && !reset_i;
      // In FULL an accepted beat is always the back-to-back beat 0 of a new frame.
      wr_beat = (state_q == StFull) ? '0 : cnt_q;
   end

   // Next state and beat counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StFill: begin
            if (accept) begin
               if (cnt_q == cnt_w_lp'(beats_lp - 1)) begin
                  state_d = StFull;
                  cnt_d   = cnt_w_lp'(beats_lp);
               end else begin
                  cnt_d = cnt_q + cnt_w_lp'(1);
               end
            end
         end
         StFull: begin
            if (bus.ready_i) begin
               if (accept) begin
                  // With a single beat per frame the new beat completes it at once.
                  if (beats_lp == 1) begin
                     state_d = StFull;
                     cnt_d   = cnt_w_lp'(beats_lp);
                  end else begin
                     state_d = StFill;
                     cnt_d   = cnt_w_lp'(1);
                  end
               end else begin
                  state_d = StFill;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = StFill;
            cnt_d   = '0;
         end
      endcase
   end

   // Storage write: all lanes of the accepted beat land in their element slots.
   always_comb begin
      mem_d = mem_q;
      if (accept) begin
         for (int unsigned i = 0; i < depth_p; i++) begin
            if (cnt_w_lp'(i / lanes_p) == wr_beat) begin
               mem_d[i] = bus.data_i[(i % lanes_p) * width_p +: width_p];
            end
         end
      end
   end

   // Control state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StFill;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef SIPO_RV_CLEAR_ON_RESET_EN
   // Storage register, cleared by reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end
`else
   // Storage register, no reset; stale contents survive until overwritten.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end
`endif

   // Outputs: frame is a direct read of storage.
   always_comb begin
      bus.ready_o = ready;
      bus.valid_o = (state_q == StFull);
      bus.data_o  = mem_q;
      bus.count_o = cnt_q;
   end
endmodule

// File: tb/tb_sipo_rv.sv
// Bench for sipo_rv (width 8, depth 4, lanes 2). A reference model advances on each
// rising edge from the applied inputs and queues every completed frame; a separate
// monitor on the falling edge compares outputs and pops frames as they are consumed.
module tb_sipo_rv;
   localparam int unsigned W     = 8;
   localparam int unsigned D     = 4;
   localparam int unsigned L     = 2;
   localparam int unsigned BEATS = D / L;

   logic clk;
   logic rst;

   sipo_rv_if #(.width_p(W), .depth_p(D), .lanes_p(L)) bus ();

   sipo_rv #(.width_p(W), .depth_p(D), .lanes_p(L)) dut (
      .clk_i  (clk),
      .reset_i(rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   bit             m_held = 1'b0;
   int             m_cnt  = 0;
   logic [W-1:0]   m_mem[D];
   bit             m_known[D];
   logic [W*D-1:0] exp_q[$];
   bit             started = 1'b0;

   function automatic logic [W*D-1:0] m_vec();
      logic [W*D-1:0] v;
      for (int i = 0; i < D; i++) v[i*W +: W] = m_mem[i];
      return v;
   endfunction

   function automatic bit all_known();
      for (int i = 0; i < D; i++) if (!m_known[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Advance the model by one rising edge using the inputs applied for it.
   task automatic model_update();
      bit rdy;
      bit acc;
      if (rst) begin
         m_held = 1'b0;
         m_cnt  = 0;
         exp_q.delete();
`ifdef SIPO_RV_CLEAR_ON_RESET_EN
         for (int i = 0; i < D; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b1;
         end
`endif
      end else begin
         rdy = !m_held || bus.ready_i;
         acc = bus.valid_i && rdy;
         if (m_held && bus.ready_i) begin
            m_held = 1'b0;
            m_cnt  = 0;
         end
         if (acc) begin
            for (int l = 0; l < L; l++) begin
               m_mem[m_cnt*L + l]   = bus.data_i[l*W +: W];
               m_known[m_cnt*L + l] = 1'b1;
            end
            m_cnt++;
            if (m_cnt == BEATS) begin
               m_held = 1'b1;
               exp_q.push_back(m_vec());
            end
         end
      end
      started = 1'b1;
   endtask

   // Apply one cycle of inputs, advance the model at the edge, then release.
   task automatic step(input bit r, input bit v, input logic [W*L-1:0] d, input bit rdy);
      rst         = r;
      bus.valid_i = v;
      bus.data_i  = d;
      bus.ready_i = rdy;
      @(posedge clk);
      model_update();
      #1;
   endtask

   // Monitor: outputs against the model, frames against the scoreboard.
   always @(negedge clk) begin
      if (started) begin
         chk("valid_o", 64'(bus.valid_o), 64'(m_held));
         chk("ready_o", 64'(bus.ready_o), 64'(!m_held || bus.ready_i));
         chk("count_o", 64'(bus.count_o), 64'(m_cnt));
         if (all_known()) chk("data_o", 64'(bus.data_o), 64'(m_vec()));
         if (bus.valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL frame got %h expected none queued at %0t", bus.data_o, $time);
            end else begin
               chk("frame", 64'(bus.data_o), 64'(exp_q[0]));
               if (bus.ready_i && !rst) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < D; i++) begin
         m_mem[i]   = 'x;
         m_known[i] = 1'b0;
      end
      rst         = 1'b1;
      bus.valid_i = 1'b0;
      bus.data_i  = '0;
      bus.ready_i = 1'b0;

      // Reset held for two cycles.
      step(1, 0, 16'h0000, 0);
      step(1, 0, 16'h0000, 0);
      // Basic fill, then stalled offers while the frame is held.
      step(0, 1, 16'h2211, 0);
      step(0, 1, 16'h4433, 0);
      step(0, 1, 16'hAAAA, 0);
      step(0, 1, 16'hBBBB, 0);
      // Back-to-back consume plus new beat 0, then complete the next frame.
      step(0, 1, 16'h6655, 1);
      step(0, 1, 16'h8877, 0);
      step(0, 0, 16'h0000, 0);
      // Streaming at full rate.
      for (int i = 0; i < 8; i++) step(0, 1, 16'(16'h0101 * (i + 1)), 1);
      step(0, 0, 16'h0000, 1);
      // Reset mid-fill, then a fresh two-beat frame.
      step(0, 1, 16'hC1C0, 0);
      step(1, 0, 16'h0000, 0);
      step(0, 1, 16'hD1D0, 0);
      step(0, 1, 16'hD3D2, 0);
      step(0, 0, 16'h0000, 1);
      // Source stall pattern 1,0,0,1.
      step(0, 1, 16'hE1E0, 0);
      step(0, 0, 16'h0000, 0);
      step(0, 0, 16'h0000, 0);
      step(0, 1, 16'hE3E2, 0);
      step(0, 0, 16'h0000, 1);
      // Randomized traffic with occasional reset.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
              16'($urandom), ($urandom_range(0, 3) != 0));
      end
      step(0, 0, 16'h0000, 1);
      @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sipo_rv.md
# sipo_rv

Multi-lane serial-in/parallel-out buffer with valid/ready handshakes on both sides. It collects `depth_p` elements, delivered `lanes_p` per beat, and presents the whole frame as one wide word. The frame is held until the downstream stage accepts it. It sits between a streaming source (memory reader, PE column output) and consumers of a full vector, such as systolic-array row/column loaders.

## Interface
Parameters:
- `width_p`, 8: bits per element.
- `depth_p`, 128: elements per frame. Must be an integer multiple of `lanes_p` and ≥ `lanes_p`.
- `lanes_p`, 1: elements accepted per input beat.
- Derived: `beats_lp` = `depth_p/lanes_p`.
- Derived: `cnt_w_lp` = `$clog2(beats_lp+1)`.

Ports:
- `clk_i`, in, 1: single clock; all state updates on the rising edge.
- `reset_i`, in, 1: synchronous, active-high reset.
- `valid_i`, in, 1: input beat valid.
- `ready_o`, out, 1: block can accept a beat this cycle.
- `data_i`, in, `width_p*lanes_p`: beat payload; lane `l` is `data_i[l*width_p +: width_p]`.
- `valid_o`, out, 1: complete frame on `data_o`.
- `ready_i`, in, 1: downstream accepts the frame.
- `data_o`, out, `width_p*depth_p`: element `i` is `data_o[i*width_p +: width_p]`.
- `count_o`, out, `cnt_w_lp`: beats stored in the current frame, range 0..`beats_lp`.

## Operation
- Storage is `depth_p` registers of `width_p` bits. `data_o` is a direct read of the storage, with no output mux.
- There are two states, FILL and FULL.
- Input handshake: a beat is accepted when `valid_i && ready_o`.
  - Beat number `k` (0-based within the frame) writes lane `l` into element `k*lanes_p + l`.
  - All lanes are written in the same cycle.
- FILL state:
  - `ready_o`=1 and `valid_o`=0.
  - Each accepted beat increments the beat counter.
  - When the accepted beat is number `beats_lp-1`, the next state is FULL and the counter becomes `beats_lp`.
- FULL state:
  - `valid_o`=1.
  - Storage does not change unless the back-to-back case below applies.
  - `ready_o` = `ready_i`, a combinational path from `ready_i` to `ready_o`.
- Output handshake: `valid_o && ready_i` completes the frame.
  - The next state is FILL and the counter returns to 0.
  - Back-to-back case: if `valid_i` is also 1 in that cycle, the beat is accepted as beat 0 of the new frame. The counter becomes 1 instead of 0.
  - In the back-to-back case, elements `0..lanes_p-1` update at the same edge.
- `beats_lp`=1 (`depth_p`==`lanes_p`): every accepted beat completes a frame.
  - A back-to-back beat returns the block straight to FULL.
- `valid_o` is asserted only after all `beats_lp` beats of a frame have been stored. It never asserts at beat `beats_lp-1` or earlier.
- Elements not yet written in the current frame keep their previous-frame values.
- `valid_i` in FULL state with `ready_i`=0 is not accepted. No storage or counter change occurs.
- The source must hold the beat until `ready_o`=1.

## Timing
- Reset (`reset_i`=1 at a rising edge) is mid-operation safe and dominates all handshakes in that cycle. It sets:
  - state to FILL;
  - counter to 0, so `count_o`=0;
  - `valid_o` to 0;
  - `ready_o` to 1.
- A partially filled frame is discarded on reset. A presented frame is dropped without handshake.
- Latency: `valid_o` rises on the edge that accepts the last beat. It is visible in the following cycle, with `data_o` already complete.
- Throughput, steady state:
  - `beats_lp` beats per frame with no bubble when `ready_i` is held at 1.
  - One frame every `beats_lp` cycles.
- `data_o` and `valid_o` are registered outputs. `ready_o` is combinational from state and `ready_i`.

## Configuration
- Macro `SIPO_RV_CLEAR_ON_RESET_EN`.
- Defined: reset also clears all `depth_p` storage elements to 0, so `data_o`=0 after reset.
- Undefined: storage has no reset. `data_o` after reset is unknown/previous contents, and only control state is reset.
- The handshake and the counter are identical in both builds.

## Test plan
All scenarios use `width_p`=8, `depth_p`=4, `lanes_p`=2, so `beats_lp`=2.

1. Reset with `SIPO_RV_CLEAR_ON_RESET_EN` defined:
   - Stimulus: hold `reset_i`=1 for 2 cycles.
   - Required: `valid_o`=0, `ready_o`=1, `count_o`=0, `data_o`=0x00000000.
2. Basic fill:
   - Stimulus: beats 0x2211 then 0x4433 on consecutive cycles, with `ready_i`=0.
   - Required: `count_o` goes 1 then 2; `valid_o`=1 one cycle after the second beat; `data_o`=0x44332211.
   - Then: `ready_o`=0 while `ready_i`=0, and further `valid_i` is ignored.
3. Back-to-back:
   - Stimulus: in FULL, assert `ready_i`=1 with `valid_i`=1 and data 0x6655.
   - Required: the frame is consumed; next cycle `valid_o`=0, `count_o`=1, `data_o`=0x44336655.
   - Then: a further beat 0x8877 gives `valid_o`=1 and `data_o`=0x88776655.
4. Streaming:
   - Stimulus: `ready_i`=1 and `valid_i`=1 continuously for 8 cycles with incrementing data.
   - Required: `valid_o` pulses every 2nd cycle, 4 frames in total with correct packing, and no dropped beat.
5. Reset mid-fill:
   - Stimulus: after 1 beat, pulse `reset_i` for 1 cycle, then send 2 beats.
   - Required: `valid_o` asserts only after those 2 new beats, never after the first new beat.
6. Source stall:
   - Stimulus: in FILL, `valid_i` toggles 1,0,0,1.
   - Required: `count_o` advances only on the cycles where `valid_i`=1.
